// File: rtl/tone_sequencer.sv
// tone_sequencer
//
// Plays a square-wave tone for one of N_CH trigger channels at a time.
// Higher channel index has priority. A tone lasts `duration` cycles with a
// half-period taken from that channel's slice of `half_period`. Lower-priority
// triggers are remembered as sticky pending bits. Pending channels are played
// after a silent gap of GAP_CYCLES cycles.
//
// All outputs are registered. They therefore show the internal state one cycle
// later. A trigger sampled at edge n gives sound=1 after edge n+1.
//
// Ports:
//   clk         - single clock, rising edge
//   rst         - synchronous active-high reset
//   trig        - per-channel trigger requests (N_CH bits)
//   half_period - packed per-channel half-periods, channel c at [c*HP_W +: HP_W]
//   duration    - tone length in cycles, shared by all channels
//   mute        - forces sound low (registered), timing unaffected
//   sound       - registered square-wave output
//   busy        - sequencer is not idle
//   cur_ch      - channel currently (or most recently) playing
//   done        - one-cycle pulse when a tone runs its full duration
module tone_sequencer #(
  parameter int N_CH       = 3,
  parameter int HP_W       = 17,
  parameter int DUR_W      = 24,
  parameter int GAP_CYCLES = 16,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        trig,
  input  logic [N_CH*HP_W-1:0]   half_period,
  input  logic [DUR_W-1:0]       duration,
  input  logic                   mute,
  output logic                   sound,
  output logic                   busy,
  output logic [CH_W-1:0]        cur_ch,
  output logic                   done
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [N_CH-1:0]   pend_q, pend_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [HP_W-1:0]   phase_q, phase_d;
  logic              tone_q, tone_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              sound_q, sound_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;

  logic [N_CH-1:0]   req;
  logic              req_any;
  logic [CH_W-1:0]   req_hi;
  logic              trig_any;
  logic [CH_W-1:0]   trig_hi;
  logic              trig_cur;
  logic              start;
  logic [CH_W-1:0]   start_ch;
  logic [HP_W-1:0]   start_hp_raw;
  logic [DUR_W-1:0]  dur_start;

  // Index of the highest set bit (0 when the vector is empty).
  function automatic logic [CH_W-1:0] hi_index(input logic [N_CH-1:0] v);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (v[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] idx);
    return {{(N_CH-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign req       = pend_q | trig;
  assign req_any   = |req;
  assign req_hi    = hi_index(req);
  assign trig_any  = |trig;
  assign trig_hi   = hi_index(trig);
  assign trig_cur  = |(trig & onehot(ch_q));
  // A zero duration is played as a single cycle.
  assign dur_start = (duration == '0) ? DUR_W'(1) : duration;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    ch_d         = ch_q;
    hp_d         = hp_q;
    dur_d        = dur_q;
    phase_d      = phase_q;
    tone_d       = tone_q;
    gap_d        = gap_q;
    done_d       = 1'b0;
    start        = 1'b0;
    start_ch     = ch_q;
    start_hp_raw = '0;

    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          start    = 1'b1;
          start_ch = req_hi;
          pend_d   = req & ~onehot(req_hi);
        end
      end

      S_PLAY: begin
        if (trig_any && (trig_hi > ch_q)) begin
          // Preemption: the interrupted channel is dropped, not re-queued.
          start    = 1'b1;
          start_ch = trig_hi;
          pend_d   = req & ~onehot(trig_hi) & ~onehot(ch_q);
        end else begin
          pend_d = req & ~onehot(ch_q);
          if (phase_q == hp_q - HP_W'(1)) begin
            phase_d = '0;
            tone_d  = ~tone_q;
          end else begin
            phase_d = phase_q + HP_W'(1);
          end
          if (trig_cur) begin
            // Retrigger extends the tone and keeps the waveform phase.
            dur_d = dur_start;
          end else if (dur_q <= DUR_W'(1)) begin
            done_d  = 1'b1;
            dur_d   = '0;
            gap_d   = '0;
            state_d = (|pend_d) ? S_GAP : S_IDLE;
          end else begin
            dur_d = dur_q - DUR_W'(1);
          end
        end
      end

      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          start    = 1'b1;
          start_ch = req_hi;
          pend_d   = req & ~onehot(req_hi);
        end else begin
          gap_d  = gap_q + GAP_W'(1);
          pend_d = req;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    for (int i = 0; i < N_CH; i++) begin
      if (CH_W'(i) == start_ch) start_hp_raw = half_period[i*HP_W +: HP_W];
    end

    // Tone start: the first PLAY cycle always begins with the high half.
    if (start) begin
      state_d = S_PLAY;
      ch_d    = start_ch;
      hp_d    = (start_hp_raw == '0) ? HP_W'(1) : start_hp_raw;
      dur_d   = dur_start;
      phase_d = '0;
      tone_d  = 1'b1;
    end

    sound_d  = tone_q & (state_q == S_PLAY) & ~mute;
    busy_d   = (state_q != S_IDLE);
    cur_ch_d = ch_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      ch_q     <= '0;
      hp_q     <= '0;
      dur_q    <= '0;
      phase_q  <= '0;
      tone_q   <= 1'b0;
      gap_q    <= '0;
      sound_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cur_ch_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      ch_q     <= ch_d;
      hp_q     <= hp_d;
      dur_q    <= dur_d;
      phase_q  <= phase_d;
      tone_q   <= tone_d;
      gap_q    <= gap_d;
      sound_q  <= sound_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cur_ch_q <= cur_ch_d;
    end
  end

  assign sound  = sound_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign cur_ch = cur_ch_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Testbench for tone_sequencer: directed scenarios followed by random traffic,
// all compared cycle by cycle against a behavioural model of the sequencer.
module tb_tone_sequencer;

   localparam int N_CH       = 3;
   localparam int HP_W       = 17;
   localparam int DUR_W      = 24;
   localparam int GAP_CYCLES = 16;

   localparam int M_IDLE = 0;
   localparam int M_PLAY = 1;
   localparam int M_GAP  = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N_CH-1:0]      trig;
   logic [N_CH*HP_W-1:0] half_period;
   logic [DUR_W-1:0]     duration;
   logic                 mute;
   logic                 sound;
   logic                 busy;
   logic [1:0]           cur_ch;
   logic                 done;

   int checkCount = 0;
   int passCount  = 0;

   // Behavioural model state: the tone's waveform is derived from the number
   // of cycles it has been playing rather than from a phase counter.
   int            mMode    = M_IDLE;
   int            mCh      = 0;
   int            mHp      = 1;
   int            mLeft    = 0;
   int            mElapsed = 0;
   int            mGapLeft = 0;
   bit [N_CH-1:0] mPend    = '0;
   bit            expSound = 1'b0;
   bit            expBusy  = 1'b0;
   bit            expDone  = 1'b0;
   int            expCur   = 0;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   tone_sequencer #(
      .N_CH(N_CH), .HP_W(HP_W), .DUR_W(DUR_W), .GAP_CYCLES(GAP_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .trig(trig), .half_period(half_period),
      .duration(duration), .mute(mute), .sound(sound), .busy(busy),
      .cur_ch(cur_ch), .done(done)
   );

   function automatic int highestOf(input bit [N_CH-1:0] v);
      int h;
      h = -1;
      for (int i = 0; i < N_CH; i++) if (v[i]) h = i;
      return h;
   endfunction

   function automatic int hpOf(input int c);
      int v;
      v = int'(half_period[c*HP_W +: HP_W]);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic int durNow();
      return (duration == '0) ? 1 : int'(duration);
   endfunction

   task automatic setHp(input int c, input int v);
      half_period[c*HP_W +: HP_W] = HP_W'(v);
   endtask

   task automatic modelStart(input int c);
      mMode    = M_PLAY;
      mCh      = c;
      mHp      = hpOf(c);
      mLeft    = durNow();
      mElapsed = 0;
   endtask

   // One clock edge of the model. Outputs seen after the edge describe the
   // cycle before it; the done pulse marks a tone that just ran out.
   task automatic modelStep();
      bit [N_CH-1:0] t;
      bit [N_CH-1:0] r;
      int            h;
      t = trig;
      if (rst) begin
         mMode = M_IDLE; mPend = '0; mCh = 0; mLeft = 0; mElapsed = 0;
         expSound = 1'b0; expBusy = 1'b0; expDone = 1'b0; expCur = 0;
         return;
      end
      expSound = (mMode == M_PLAY) && (((mElapsed / mHp) % 2) == 0) && !mute;
      expBusy  = (mMode != M_IDLE);
      expCur   = mCh;
      expDone  = 1'b0;
      case (mMode)
         M_IDLE: begin
            r = t | mPend;
            if (r != '0) begin
               h = highestOf(r);
               r[h] = 1'b0;
               mPend = r;
               modelStart(h);
            end
         end
         M_PLAY: begin
            h = highestOf(t);
            if (h > mCh) begin
               r = t | mPend;
               r[h] = 1'b0;
               r[mCh] = 1'b0;
               mPend = r;
               modelStart(h);
            end else if (t[mCh]) begin
               t[mCh] = 1'b0;
               mPend = mPend | t;
               mLeft = durNow();
               mElapsed++;
            end else begin
               mPend = mPend | t;
               if (mLeft == 1) begin
                  expDone = 1'b1;
                  if (mPend != '0) begin
                     mMode = M_GAP; mGapLeft = GAP_CYCLES;
                  end else begin
                     mMode = M_IDLE;
                  end
               end else begin
                  mLeft--;
                  mElapsed++;
               end
            end
         end
         default: begin
            if (mGapLeft == 1) begin
               r = t | mPend;
               h = highestOf(r);
               r[h] = 1'b0;
               mPend = r;
               modelStart(h);
            end else begin
               mPend = mPend | t;
               mGapLeft--;
            end
         end
      endcase
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Drive one cycle of inputs, step the model on the edge and compare all
   // outputs half a cycle later.
   task automatic applyStimulus(input bit [N_CH-1:0] t, input bit m, input bit r);
      trig = t; mute = m; rst = r;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput("sound", 32'(sound), 32'(expSound));
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("done", 32'(done), 32'(expDone));
      checkOutput("cur_ch", 32'(cur_ch), 32'(expCur));
   endtask

   task automatic runIdle(input int n);
      for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, 1'b0);
   endtask

   // Directed scenarios first, then random triggers, mute, reset and
   // parameter changes, all judged by the model.
   initial begin
      logic [19:0] soundPat;
      logic [19:0] donePat;
      half_period = '0;
      setHp(0, 4); setHp(1, 3); setHp(2, 2);
      duration = DUR_W'(20);
      soundPat = '0;
      donePat  = '0;

      applyStimulus('0, 1'b0, 1'b1);
      applyStimulus(3'b111, 1'b0, 1'b1);
      runIdle(2);

      // Single tone on channel 0 with an explicit waveform check.
      applyStimulus(3'b001, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus('0, 1'b0, 1'b0);
         soundPat = {soundPat[18:0], sound};
         donePat  = {donePat[18:0], done};
      end
      checkOutput("pattern_sound", 32'(soundPat), 32'h000F0F0F);
      checkOutput("pattern_done", 32'(donePat), 32'h00000001);
      applyStimulus('0, 1'b0, 1'b0);
      checkOutput("busy_after_tone", 32'(busy), 32'h0);
      runIdle(3);

      // Preemption by channel 2.
      applyStimulus(3'b001, 1'b0, 1'b0);
      runIdle(4);
      applyStimulus(3'b100, 1'b0, 1'b0);
      runIdle(40);

      // Queued lower channels played after gaps.
      applyStimulus(3'b100, 1'b0, 1'b0);
      runIdle(5);
      applyStimulus(3'b010, 1'b0, 1'b0);
      runIdle(2);
      applyStimulus(3'b001, 1'b0, 1'b0);
      runIdle(110);

      // Retrigger near the end of a tone.
      applyStimulus(3'b010, 1'b0, 1'b0);
      runIdle(16);
      applyStimulus(3'b010, 1'b0, 1'b0);
      runIdle(30);

      // Zero half-period and zero duration.
      setHp(0, 0); duration = '0;
      applyStimulus(3'b001, 1'b0, 1'b0);
      runIdle(4);
      setHp(0, 4); duration = DUR_W'(20);

      // Mute mid-tone.
      applyStimulus(3'b001, 1'b0, 1'b0);
      runIdle(5);
      for (int i = 0; i < 6; i++) applyStimulus('0, 1'b1, 1'b0);
      runIdle(15);

      // Reset in the middle of a gap.
      applyStimulus(3'b100, 1'b0, 1'b0);
      runIdle(3);
      applyStimulus(3'b011, 1'b0, 1'b0);
      runIdle(22);
      applyStimulus('0, 1'b0, 1'b1);
      checkOutput("busy_after_rst", 32'(busy), 32'h0);
      runIdle(60);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         bit [N_CH-1:0] t;
         if ($urandom_range(0, 30) == 0) setHp(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 6)));
         if ($urandom_range(0, 30) == 0) duration = DUR_W'($urandom_range(0, 30));
         t = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '0;
         applyStimulus(t, $urandom_range(0, 15) == 0, $urandom_range(0, 499) == 0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
